// File: rtl/rightmost_set_bit_drain.sv
// Drains a bitmask one set bit per cycle, lowest bit first,
// emitting each bit as a one-hot mask plus its binary index.
module rightmost_set_bit_drain #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [WORD_WIDTH-1:0]  input_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [WORD_WIDTH-1:0]  output_onehot,
  output logic [INDEX_WIDTH-1:0] output_index,
  output logic                   output_last
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

  state_t                 state;
  logic [WORD_WIDTH-1:0]  remaining;
  logic                   armed;
  logic                   drain;
  logic [WORD_WIDTH-1:0]  lowest;
  logic [WORD_WIDTH-1:0]  rest;
  logic [INDEX_WIDTH-1:0] enc;
  logic                   in_fire;
  logic                   out_fire;
  logic                   nonzero;

  assign drain  = (state == DRAIN);
  assign lowest = remaining & (~remaining + ONE);
  assign rest   = remaining & (remaining - ONE);

  always_comb begin
    enc = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (lowest[i]) enc = INDEX_WIDTH'(i);
    end
  end

  assign output_valid  = drain;
  assign output_onehot = drain ? lowest : '0;
  assign output_index  = drain ? enc : '0;
  assign output_last   = drain && (rest == '0);

  // armed holds ready low until the first edge after reset
  assign input_ready = drain ? (output_ready & output_last)
                             : armed;

  assign in_fire  = input_valid & input_ready;
  assign out_fire = output_valid & output_ready;
  assign nonzero  = (input_data != '0);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      remaining <= '0;
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_fire && nonzero) begin
            remaining <= input_data;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (output_last) begin
              if (in_fire && nonzero) begin
                remaining <= input_data;
              end else begin
                remaining <= '0;
                state     <= IDLE;
              end
            end else begin
              remaining <= rest;
            end
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rightmost_set_bit_drain.sv
// Scoreboard bench: expected items queued on input handshake,
// popped and compared on each output handshake.
module tb_rightmost_set_bit_drain;

  typedef struct packed {
    logic [7:0] onehot;
    logic [2:0] index;
    logic       last;
  } item_t;

  logic       clock;
  logic       clear_n;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] input_data;
  logic       output_valid;
  logic       output_ready;
  logic [7:0] output_onehot;
  logic [2:0] output_index;
  logic       output_last;

  logic       w2_iv;
  logic       w2_ir;
  logic [1:0] w2_id;
  logic       w2_ov;
  logic       w2_or;
  logic [1:0] w2_oh;
  logic [0:0] w2_ix;
  logic       w2_ol;

  int tests;
  int failed;

  item_t sb[$];

  logic       stall_prev;
  logic [7:0] prev_onehot;
  logic [2:0] prev_index;
  logic       prev_last;

  rightmost_set_bit_drain #(
    .WORD_WIDTH(8),
    .INDEX_WIDTH(3)
  ) dut (
    .clock(clock),
    .clear_n(clear_n),
    .input_valid(input_valid),
    .input_ready(input_ready),
    .input_data(input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_onehot(output_onehot),
    .output_index(output_index),
    .output_last(output_last)
  );

  rightmost_set_bit_drain #(
    .WORD_WIDTH(2),
    .INDEX_WIDTH(1)
  ) dut2 (
    .clock(clock),
    .clear_n(clear_n),
    .input_valid(w2_iv),
    .input_ready(w2_ir),
    .input_data(w2_id),
    .output_valid(w2_ov),
    .output_ready(w2_or),
    .output_onehot(w2_oh),
    .output_index(w2_ix),
    .output_last(w2_ol)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    item_t it;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) begin
        it.onehot = 8'(1) << i;
        it.index  = 3'(i);
        it.last   = ((w >> (i + 1)) == 8'h00);
        sb.push_back(it);
      end
    end
  endtask

  // Entered and left at posedge+1; holds input_valid on return.
  task automatic send(input logic [7:0] w);
    bit done;
    done = 0;
    input_valid = 1'b1;
    input_data  = w;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock);
      if (input_ready) begin
        push_word(w);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain(input bit rnd);
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (sb.size() == 0) begin
        done = 1;
      end else begin
        if (rnd) output_ready = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    output_ready = 1'b1;
  endtask

  always @(negedge clear_n) stall_prev = 1'b0;

  always @(negedge clock) begin
    if (clear_n) begin
      if (stall_prev) begin
        check("stall_valid", output_valid, 1);
        check("stall_onehot", output_onehot, prev_onehot);
        check("stall_index", output_index, prev_index);
        check("stall_last", output_last, prev_last);
      end
      if (output_valid && output_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_item", output_onehot, 0);
        end else begin
          item_t e;
          e = sb.pop_front();
          check("item_onehot", output_onehot, e.onehot);
          check("item_index", output_index, e.index);
          check("item_last", output_last, e.last);
        end
      end
      stall_prev  = output_valid && !output_ready;
      prev_onehot = output_onehot;
      prev_index  = output_index;
      prev_last   = output_last;
    end
  end

  initial begin
    tests        = 0;
    failed       = 0;
    stall_prev   = 1'b0;
    clear_n      = 1'b0;
    input_valid  = 1'b0;
    input_data   = 8'h00;
    output_ready = 1'b1;
    w2_iv        = 1'b0;
    w2_id        = 2'b00;
    w2_or        = 1'b1;

    #3;
    check("rst_valid", output_valid, 0);
    check("rst_ready", input_ready, 0);
    check("rst_onehot", output_onehot, 0);
    check("rst_index", output_index, 0);
    check("rst_last", output_last, 0);
    #19;
    clear_n = 1'b1;
    #1;
    check("rel_ready_before_edge", input_ready, 0);
    @(posedge clock);
    #1;
    check("rel_ready_after_edge", input_ready, 1);

    // basic drain
    send(8'hA6);
    input_valid = 1'b0;
    wait_drain(0);
    check("basic_idle_valid", output_valid, 0);
    check("basic_idle_ready", input_ready, 1);

    // random back-pressure on all-ones
    output_ready = 1'b0;
    send(8'hFF);
    input_valid = 1'b0;
    check("bp_queued", sb.size(), 8);
    wait_drain(1);
    check("bp_idle_valid", output_valid, 0);

    // zero word
    send(8'h00);
    input_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("zero_valid", output_valid, 0);
      check("zero_ready", input_ready, 1);
    end
    @(posedge clock);
    #1;

    // MSB only
    send(8'h80);
    input_valid = 1'b0;
    wait_drain(0);
    check("msb_idle_valid", output_valid, 0);

    // back-to-back words
    send(8'h01);
    send(8'h18);
    input_valid = 1'b0;
    @(negedge clock);
    check("b2b_valid_1", output_valid, 1);
    @(negedge clock);
    check("b2b_valid_2", output_valid, 1);
    @(posedge clock);
    #1;
    wait_drain(0);
    check("b2b_idle_valid", output_valid, 0);

    // reset in the middle of a drain
    output_ready = 1'b0;
    send(8'hF0);
    input_valid  = 1'b0;
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    output_ready = 1'b0;
    check("mid_valid_before", output_valid, 1);
    clear_n = 1'b0;
    #1;
    check("mid_valid_in_rst", output_valid, 0);
    check("mid_ready_in_rst", input_ready, 0);
    check("mid_onehot_in_rst", output_onehot, 0);
    #1;
    clear_n = 1'b1;
    check("mid_consumed", sb.size(), 3);
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    check("mid_ready_after", input_ready, 1);
    check("mid_valid_after", output_valid, 0);
    @(posedge clock);
    #1;
    output_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("mid_no_leftover", output_valid, 0);
    end
    @(posedge clock);
    #1;
    send(8'h02);
    input_valid = 1'b0;
    wait_drain(0);

    // two-bit instance
    w2_iv = 1'b1;
    w2_id = 2'b11;
    @(negedge clock);
    check("w2_ready", w2_ir, 1);
    @(posedge clock);
    #1;
    w2_iv = 1'b0;
    @(negedge clock);
    check("w2_v0", w2_ov, 1);
    check("w2_oh0", w2_oh, 2'b01);
    check("w2_ix0", w2_ix, 0);
    check("w2_l0", w2_ol, 0);
    @(negedge clock);
    check("w2_v1", w2_ov, 1);
    check("w2_oh1", w2_oh, 2'b10);
    check("w2_ix1", w2_ix, 1);
    check("w2_l1", w2_ol, 1);
    @(negedge clock);
    check("w2_idle", w2_ov, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
